// File: rtl/chebyshev_series_engine.sv
// Truncated Chebyshev series evaluator: y = sum c_k*T_k(x), k=0..ORDER.
// T_k comes from the forward recurrence T_{k+1} = 2x*T_k - T_{k-1}, saturated
// to TW bits. Coefficients arrive one per beat on a valid/ready stream.
module chebyshev_series_engine #(
  parameter  int WL       = 8,
  parameter  int FX       = 6,
  parameter  int CL       = 8,
  parameter  int ORDER    = 3,
  parameter  int GUARD    = 2,
  parameter  int WIDENING = 1,
  localparam int TW       = WL + GUARD,
  localparam int AW       = TW + CL + $clog2(ORDER + 1) + WIDENING
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          start,
  input  logic [WL-1:0] data_in,
  output logic          busy,
  input  logic [CL-1:0] coeff_in,
  input  logic          coeff_valid,
  output logic          coeff_ready,
  output logic [AW-1:0] data_out,
  output logic          out_valid,
  output logic          sat_flag
);

  localparam int KW = $clog2(ORDER + 1);
  localparam int PW = CL + TW;        // coefficient * term product
  localparam int RW = WL + TW + 2;    // recurrence intermediate, never wraps

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [KW-1:0] KLAST = KW'(ORDER);

  logic [1:0]           state;
  logic [WL-1:0]        x;
  logic [TW-1:0]        t_prev, t_cur, t_next, mop;
  logic [KW-1:0]        k;
  logic [AW-1:0]        acc, acc_next;
  logic [PW-1:0]        cprod;
  logic signed [RW-1:0] xprod, twox, shr, rec;
  logic                 sat_sticky, beat, ovf;

  assign coeff_ready = (state == S_ITER);
  assign busy        = (state != S_IDLE);
  assign out_valid   = (state == S_DONE);
  assign beat        = coeff_ready & coeff_valid;

  // MAC term and next Chebyshev term; at k=0 t_prev still holds 1.0, so the
  // same multiplier gives c_0*2^FX.
  always_comb begin
    mop      = (k == '0) ? t_prev : t_cur;
    cprod    = {{TW{coeff_in[CL-1]}}, coeff_in} * {{CL{mop[TW-1]}}, mop};
    acc_next = acc + {{(AW-PW){cprod[PW-1]}}, cprod};
    xprod    = {{(RW-WL){x[WL-1]}}, x} * {{(RW-TW){t_cur[TW-1]}}, t_cur};
    twox     = xprod <<< 1;
    shr      = twox >>> FX;
    rec      = shr - {{(RW-TW){t_prev[TW-1]}}, t_prev};
    // anything above the TW sign bit that is not pure sign extension overflows
    ovf      = !((&rec[RW-1:TW-1]) || !(|rec[RW-1:TW-1]));
    if (ovf) t_next = rec[RW-1] ? {1'b1, {(TW-1){1'b0}}} : {1'b0, {(TW-1){1'b1}}};
    else     t_next = rec[TW-1:0];
  end

  // Sequencer: latch x, consume ORDER+1 coefficient beats, present result.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      x          <= '0;
      t_prev     <= '0;
      t_cur      <= '0;
      k          <= '0;
      acc        <= '0;
      sat_sticky <= 1'b0;
      data_out   <= '0;
      sat_flag   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          x          <= data_in;
          t_prev     <= TW'(1 << FX);
          t_cur      <= TW'($signed(data_in));
          k          <= '0;
          acc        <= '0;
          sat_sticky <= 1'b0;
          state      <= S_ITER;
        end
        S_ITER: if (beat) begin
          acc <= acc_next;
          if (k == KLAST) begin
            // the term computed on the last beat is never used
            data_out <= acc_next;
            sat_flag <= sat_sticky;
            state    <= S_DONE;
          end else begin
            k <= k + KW'(1);
            if (k != '0) begin
              t_prev     <= t_cur;
              t_cur      <= t_next;
              sat_sticky <= sat_sticky | ovf;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chebyshev_series_engine.sv
// Randomised bench for chebyshev_series_engine with a behavioural series model
// and a per-cycle output compare process.
module tb_chebyshev_series_engine;

  localparam int WL = 8, FX = 6, CL = 8, ORDER = 3, GUARD = 2, WIDENING = 1;
  localparam int TW = WL + GUARD;
  localparam int AW = TW + CL + $clog2(ORDER + 1) + WIDENING;

  typedef int coef_t[0:ORDER];
  typedef struct { int val; bit sat; int cyc; } exp_t;

  logic          clock, resetn, start, coeff_valid;
  logic [WL-1:0] data_in;
  logic [CL-1:0] coeff_in;
  logic          busy, coeff_ready, out_valid, sat_flag;
  logic [AW-1:0] data_out;

  chebyshev_series_engine #(
    .WL(WL), .FX(FX), .CL(CL), .ORDER(ORDER), .GUARD(GUARD), .WIDENING(WIDENING)
  ) dut (
    .clock(clock), .resetn(resetn), .start(start), .data_in(data_in),
    .busy(busy), .coeff_in(coeff_in), .coeff_valid(coeff_valid),
    .coeff_ready(coeff_ready), .data_out(data_out), .out_valid(out_valid),
    .sat_flag(sat_flag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int   nchk = 0, nfail = 0;
  exp_t q[$];
  int   last_val = 0;
  bit   last_sat = 1'b0;

  task automatic check(input string name, input longint act, input longint req);
    nchk++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Series value straight from the definition: build T_0..T_ORDER with a
  // floor-divided recurrence and clamp, then take the dot product.
  function automatic void model(input int xv, input coef_t c, output int y, output bit s);
    longint t[0:ORDER];
    longint p, lo, hi, sum;
    lo = -(longint'(1) << (TW - 1));
    hi = (longint'(1) << (TW - 1)) - 1;
    s = 1'b0;
    t[0] = longint'(1) << FX;
    t[1] = xv;
    for (int j = 2; j <= ORDER; j++) begin
      p = ((2 * longint'(xv) * t[j-1]) >>> FX) - t[j-2];
      if (p > hi) begin p = hi; s = 1'b1; end
      if (p < lo) begin p = lo; s = 1'b1; end
      t[j] = p;
    end
    sum = 0;
    for (int j = 0; j <= ORDER; j++) sum += longint'(c[j]) * t[j];
    y = int'(sum);
  endfunction

  // Output monitor: every out_valid must match the next queued expectation at
  // its predicted cycle; between results the outputs must hold.
  always @(negedge clock) begin
    exp_t e;
    if (!resetn) begin
      last_val = 0;
      last_sat = 1'b0;
    end else if (out_valid) begin
      if (q.size() == 0) check("spurious_out_valid", 1, 0);
      else begin
        e = q.pop_front();
        check("data_out", $signed(data_out), e.val);
        check("sat_flag", sat_flag, e.sat);
        check("out_cycle", cyc, e.cyc);
        last_val = e.val;
        last_sat = e.sat;
      end
    end else begin
      check("data_out_hold", $signed(data_out), last_val);
      check("sat_flag_hold", sat_flag, last_sat);
    end
  end

  // One evaluation: wait for idle, start, then feed coefficients with
  // stall[k] idle cycles ahead of beat k.
  task automatic run_eval(input int xv, input coef_t c, input coef_t stall,
                          input bit hold_start, input bit junk_valid);
    int n = 0, total = 0, y, acc_cyc;
    bit s;
    while (busy && n < 50) begin @(posedge clock); #1; n++; end
    if (busy) begin check("idle_timeout", 1, 0); return; end
    start   = 1'b1;
    data_in = WL'(xv);
    acc_cyc = cyc;
    for (int j = 0; j <= ORDER; j++) total += stall[j];
    model(xv, c, y, s);
    q.push_back('{y, s, acc_cyc + ORDER + 2 + total});
    @(posedge clock); #1;
    if (!hold_start) start = 1'b0;
    else data_in = WL'($urandom);
    for (int j = 0; j <= ORDER; j++) begin
      if (stall[j] > 0) begin
        coeff_valid = 1'b0;
        coeff_in    = CL'($urandom);
        repeat (stall[j]) begin @(posedge clock); #1; end
      end
      coeff_valid = 1'b1;
      coeff_in    = CL'(c[j]);
      @(posedge clock); #1;
    end
    coeff_valid = junk_valid;
    coeff_in    = CL'($urandom);
  endtask

  coef_t nost = '{default: 0};
  coef_t c, st;
  int    y, xr, n;
  bit    s;

  initial begin
    resetn = 1'b0; start = 1'b0; data_in = '0; coeff_in = '0; coeff_valid = 1'b0;

    // pin the model with hand-computed series values
    model(32, '{1, 2, 3, 4}, y, s);  check("model_nominal", y, -224); check("model_nominal_sat", s, 0);
    model(64, '{1, 1, 1, 1}, y, s);  check("model_x_one", y, 256);
    model(-64, '{1, 1, 1, 1}, y, s); check("model_x_minus_one", y, 0);
    model(127, '{0, 0, 0, 1}, y, s); check("model_sat", y, 511); check("model_sat_flag", s, 1);

    #1;
    check("rst_data_out", data_out, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_coeff_ready", coeff_ready, 0);
    check("rst_sat_flag", sat_flag, 0);
    repeat (3) @(posedge clock);
    #1 resetn = 1'b1;
    @(posedge clock); #1;

    // nominal
    run_eval(32, '{1, 2, 3, 4}, nost, 1'b0, 1'b0);

    // abort after two beats
    @(posedge clock); #1;
    while (busy) begin @(posedge clock); #1; end
    start = 1'b1; data_in = 8'd32;
    @(posedge clock); #1;
    start = 1'b0; coeff_valid = 1'b1; coeff_in = 8'd1;
    @(posedge clock); #1;
    coeff_in = 8'd2;
    @(posedge clock); #1;
    resetn = 1'b0; coeff_valid = 1'b0;
    #1;
    check("abort_data_out", data_out, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_coeff_ready", coeff_ready, 0);
    check("abort_sat_flag", sat_flag, 0);
    @(posedge clock); #1 resetn = 1'b1;
    @(posedge clock); #1;
    run_eval(32, '{1, 2, 3, 4}, nost, 1'b0, 1'b0);

    // back-pressure between c_1 and c_2
    run_eval(32, '{1, 2, 3, 4}, '{0, 0, 3, 0}, 1'b0, 1'b0);

    // identities
    run_eval(64, '{1, 1, 1, 1}, nost, 1'b0, 1'b0);
    run_eval(-64, '{1, 1, 1, 1}, nost, 1'b0, 1'b0);

    // saturation, then a clean evaluation clears the flag
    run_eval(127, '{0, 0, 0, 1}, nost, 1'b0, 1'b0);
    run_eval(32, '{1, 2, 3, 4}, nost, 1'b0, 1'b0);

    // coefficients offered while idle must not be consumed
    coeff_valid = 1'b1; coeff_in = 8'd99;
    repeat (4) begin @(posedge clock); #1; end
    run_eval(-40, '{5, -7, 3, 2}, nost, 1'b0, 1'b1);

    // start held through ITER/DONE of a single evaluation: one result only
    run_eval(20, '{-3, 4, -5, 6}, nost, 1'b1, 1'b0);
    start = 1'b0;
    repeat (3) begin @(posedge clock); #1; end

    // start held continuously: back-to-back ORDER+3 spacing
    run_eval(10, '{1, -1, 2, -2}, nost, 1'b1, 1'b0);
    run_eval(-90, '{7, 8, -9, 10}, nost, 1'b1, 1'b0);
    run_eval(100, '{-128, 127, -1, 1}, nost, 1'b1, 1'b0);
    start = 1'b0;

    // randomised evaluations
    for (int i = 0; i < 30; i++) begin
      xr = int'($urandom_range(0, 255)) - 128;
      for (int j = 0; j <= ORDER; j++) begin
        c[j]  = int'($urandom_range(0, 255)) - 128;
        st[j] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      end
      run_eval(xr, c, st, 1'b0, 1'($urandom));
      repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
    end

    n = 0;
    while (q.size() > 0 && n < 100) begin @(posedge clock); #1; n++; end
    if (q.size() > 0) check("drain_timeout", q.size(), 0);
    repeat (3) @(posedge clock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
